// File: rtl/polar_gain_avg_pkg.sv
// Shared constants and phase wrap rule for the polar gain/average block.
// Phase is signed degrees with a configurable number of fraction bits.
package polar_pkg;

  localparam int PH_FRAC_DEF = 22;
  localparam int GAIN_COMP_DEFAULT = 159189;

  localparam logic [31:0] PH_180 = 32'd180 << PH_FRAC_DEF;
  localparam logic [31:0] PH_360 = 32'd360 << PH_FRAC_DEF;

  function automatic logic signed [63:0] wrap_ph(
    input logic signed [63:0] d,
    input int                 frac
  );
    logic signed [63:0] h;
    logic signed [63:0] f;
    h = 64'sd180 <<< frac;
    f = 64'sd360 <<< frac;
    if (d >= h)
      wrap_ph = d - f;
    else if (d < -h)
      wrap_ph = d + f;
    else
      wrap_ph = d;
  endfunction

endpackage

// File: rtl/polar_gain_avg_wrap.sv
// Single +/-360 degree correction into [-180,180).
// Input must already lie within one turn of that range.
module phase_wrap
  import polar_pkg::*;
#(
  parameter int W    = 33,
  parameter int FRAC = 22
) (
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] q
);

  assign q = W'(wrap_ph(64'(d), FRAC));

endmodule

// File: rtl/polar_gain_avg.sv
// CORDIC gain removal and frame averaging of (mag, phase) pulses.
// Three-stage pipeline: compensate/diff, accumulate, finalize/output.
module polar_gain_avg
  import polar_pkg::*;
#(
  parameter int WIDTH_XY  = 32,
  parameter int WIDTH_PH  = 32,
  parameter int PH_FRAC   = 22,
  parameter int LOG2_NAVG = 2,
  parameter int GAIN_COMP = GAIN_COMP_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       i_vld,
  input  logic signed [WIDTH_XY-1:0] i_mag,
  input  logic signed [WIDTH_PH-1:0] i_phase,
  output logic                       o_vld,
  input  logic                       o_rdy,
  output logic        [WIDTH_XY-1:0] o_mag,
  output logic signed [WIDTH_PH-1:0] o_phase,
  output logic                       o_ovr
);

  localparam int L    = LOG2_NAVG;
  localparam int WD   = WIDTH_PH + 1;
  localparam int WA   = WIDTH_PH + L + 1;
  localparam int WM   = WIDTH_XY + L;
  localparam int WS   = WIDTH_PH + 2;
  localparam int WP   = WIDTH_XY + 18;
  localparam int HALF = 1 << (L - 1);

  logic [L-1:0] idx;
  logic         first;
  logic         last;

  assign first = (idx == '0);
  assign last  = (idx == '1);

  // stage 1 combinational
  logic [WIDTH_XY-1:0]        mag_c;
  logic [WP-1:0]              prod;
  logic [WIDTH_XY-1:0]        mag_g;
  logic signed [WIDTH_PH-1:0] ph_ref;
  logic signed [WD-1:0]       diff_raw;
  logic signed [WD-1:0]       diff_w;

  assign mag_c = i_mag[WIDTH_XY-1] ? '0 : i_mag;
  assign prod  = WP'(mag_c) * WP'(GAIN_COMP)
               + WP'(1 << 17);
  assign mag_g = WIDTH_XY'(prod >> 18);

  assign diff_raw = first ? '0
                  : WD'(i_phase) - WD'(ph_ref);

  phase_wrap #(.W(WD), .FRAC(PH_FRAC)) u_wrap_d (
    .d (diff_raw),
    .q (diff_w)
  );

  logic                       s1_vld;
  logic                       s1_first;
  logic                       s1_last;
  logic [WIDTH_XY-1:0]        s1_mag;
  logic signed [WD-1:0]       s1_diff;
  logic signed [WIDTH_PH-1:0] s1_ref;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      ph_ref   <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_mag   <= '0;
      s1_diff  <= '0;
      s1_ref   <= '0;
    end else begin
      s1_vld <= i_vld;
      if (i_vld) begin
        idx      <= idx + 1'b1;
        s1_first <= first;
        s1_last  <= last;
        s1_mag   <= mag_g;
        s1_diff  <= diff_w;
        s1_ref   <= first ? i_phase : ph_ref;
        if (first)
          ph_ref <= i_phase;
      end
    end
  end

  // stage 2: the frame reference travels with the sums so the
  // next frame can start loading stage 1 without a stall
  logic [WM-1:0]              mag_acc;
  logic signed [WA-1:0]       ph_acc;
  logic signed [WIDTH_PH-1:0] acc_ref;
  logic                       frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_acc    <= '0;
      ph_acc     <= '0;
      acc_ref    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= s1_vld & s1_last;
      if (s1_vld) begin
        acc_ref <= s1_ref;
        if (s1_first) begin
          mag_acc <= WM'(s1_mag);
          ph_acc  <= WA'(s1_diff);
        end else begin
          mag_acc <= mag_acc + WM'(s1_mag);
          ph_acc  <= ph_acc + WA'(s1_diff);
        end
      end
    end
  end

  // stage 3 combinational
  logic [WM-1:0]        mag_rnd;
  logic [WIDTH_XY-1:0]  mag_avg;
  logic signed [WA-1:0] ph_rnd;
  logic signed [WA-1:0] ph_mean;
  logic signed [WS-1:0] ph_sum;
  logic signed [WS-1:0] ph_wr;

  assign mag_rnd = mag_acc + WM'(HALF);
  assign mag_avg = WIDTH_XY'(mag_rnd >> L);
  assign ph_rnd  = ph_acc + WA'(HALF);
  assign ph_mean = ph_rnd >>> L;
  assign ph_sum  = WS'(acc_ref) + WS'(ph_mean);

  phase_wrap #(.W(WS), .FRAC(PH_FRAC)) u_wrap_o (
    .d (ph_sum),
    .q (ph_wr)
  );

  logic fire;
  logic take;

  assign fire = o_vld & o_rdy;
  assign take = frame_done & (~o_vld | o_rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld   <= 1'b0;
      o_mag   <= '0;
      o_phase <= '0;
      o_ovr   <= 1'b0;
    end else begin
      if (take) begin
        o_vld   <= 1'b1;
        o_mag   <= mag_avg;
        o_phase <= WIDTH_PH'(ph_wr);
      end else if (fire) begin
        o_vld <= 1'b0;
      end
      if (clr)
        o_ovr <= 1'b0;
      else if (frame_done & o_vld & ~o_rdy)
        o_ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_polar_gain_avg.sv
// Scoreboard bench for polar_gain_avg: directed frames, queue-based
// expected results, decoupled monitor on the falling edge.
module tb_polar_gain_avg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        i_vld = 1'b0;
  logic [31:0] i_mag = '0;
  logic [31:0] i_phase = '0;
  logic        o_vld;
  logic        o_rdy = 1'b1;
  logic [31:0] o_mag;
  logic [31:0] o_phase;
  logic        o_ovr;

  int tot = 0;
  int bad = 0;
  int cyc = 0;
  int last_e = 0;

  typedef struct {
    logic [31:0] mag;
    logic [31:0] ph;
    int          cyc;
  } exp_t;

  exp_t q[$];

  localparam logic [31:0] P10  = 32'h0280_0000;
  localparam logic [31:0] P170 = 32'h2A80_0000;
  localparam logic [31:0] N170 = 32'hD580_0000;
  localparam logic [31:0] N180 = 32'hD300_0000;

  polar_gain_avg dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .i_vld   (i_vld),
    .i_mag   (i_mag),
    .i_phase (i_phase),
    .o_vld   (o_vld),
    .o_rdy   (o_rdy),
    .o_mag   (o_mag),
    .o_phase (o_phase),
    .o_ovr   (o_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] m,
                      input logic [31:0] p);
    i_vld   = 1'b1;
    i_mag   = m;
    i_phase = p;
    @(posedge clk);
    #1;
    i_vld  = 1'b0;
    last_e = cyc;
  endtask

  task automatic push(input logic [31:0] m,
                      input logic [31:0] p,
                      input int c);
    exp_t e;
    e.mag = m;
    e.ph  = p;
    e.cyc = c;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && o_vld === 1'b1 && o_rdy) begin
      if (q.size() == 0) begin
        chk("extra_out", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_mag", 64'(o_mag), 64'(e.mag));
        chk("out_phase", 64'(o_phase), 64'(e.ph));
        if (e.cyc >= 0)
          chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    step(3);
    rst = 1'b0;
    chk("rst_vld", 64'(o_vld), 64'd0);
    chk("rst_mag", 64'(o_mag), 64'd0);
    chk("rst_phase", 64'(o_phase), 64'd0);
    chk("rst_ovr", 64'(o_ovr), 64'd0);

    // basic frame with latency check
    for (int i = 0; i < 4; i++) send(32'd1_000_000, P10);
    push(32'd607258, P10, last_e + 2);
    step(8);

    // phase unwrapping across +/-180
    send(32'd1000, P170);
    send(32'd1000, N170);
    send(32'd1000, P170);
    send(32'd1000, N170);
    push(32'd607, N180, last_e + 2);
    step(8);

    // backpressure: second frame must be dropped
    o_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(32'd1000, P10);
    step(2);
    for (int i = 0; i < 4; i++) send(32'd2000, 32'd0);
    step(5);
    chk("bp_vld", 64'(o_vld), 64'd1);
    chk("bp_mag", 64'(o_mag), 64'd607);
    chk("bp_phase", 64'(o_phase), 64'(P10));
    chk("bp_ovr", 64'(o_ovr), 64'd1);
    push(32'd607, P10, -1);
    o_rdy = 1'b1;
    step(1);
    chk("bp_vld_drop", 64'(o_vld), 64'd0);
    chk("bp_ovr_hold", 64'(o_ovr), 64'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_ovr", 64'(o_ovr), 64'd0);
    step(3);

    // reset in the middle of a frame
    send(32'd50_000, P170);
    send(32'd50_000, P170);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_vld", 64'(o_vld), 64'd0);
    for (int i = 0; i < 4; i++) send(32'd2000, 32'd0);
    push(32'd1215, 32'd0, last_e + 2);
    step(8);

    // two frames back to back
    for (int i = 0; i < 4; i++) send(32'd1000, P10);
    push(32'd607, P10, last_e + 2);
    for (int i = 0; i < 4; i++) send(32'd2000, 32'd0);
    push(32'd1215, 32'd0, last_e + 2);
    step(8);
    chk("b2b_ovr", 64'(o_ovr), 64'd0);

    // negative magnitude clamps to zero
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFB, 32'd0);
    push(32'd0, 32'd0, last_e + 2);

    for (int i = 0; i < 50 && q.size() != 0; i++) step(1);
    chk("drain", 64'(q.size()), 64'd0);
    step(4);
    chk("end_vld", 64'(o_vld), 64'd0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
